user_adpt_stream_bridge: RTL and testbench

Parametrised single-clock stream bridge between the PCIe stream engine and user logic. Each of NUM_CH channels has a write-direction FIFO (PCIe → user) and a read-direction FIFO (user → PCIe), both of depth DEPTH. Each channel also has occupancy/almost-full status, a per-channel synchronous flush, and a per-channel loopback mode that returns PCIe write data to PCIe without involving user logic. It sits where the user logic adapter sits, for designs where user logic shares the PCIe clock.

---
 rtl/user_adpt_pkg.sv | 13 +
 rtl/user_adpt_sync_fifo.sv | 78 +++++++
 rtl/user_adpt_stream_bridge.sv | 92 +++++++++
 tb/tb_user_adpt_stream_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_adpt_pkg.sv
// Shared helpers for the user-adapter stream bridge: FIFO count width and
// channel slice offsets on the flattened data buses.
package user_adpt_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/user_adpt_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, occupancy count and
// almost-full flag. Input ack depends only on registered state, flush and reset.
module user_adpt_sync_fifo
    import user_adpt_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ack,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ack,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      afull
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full;
    logic              push;
    logic              pop;

    // Outputs are forced to their idle values while reset is held so that a
    // mid-stream reset hides stale contents in the reset cycle itself.
    assign full      = (cnt_q == CW'(DEPTH));
    assign in_ack    = !full && !flush && !srst;
    assign out_valid = !srst && (cnt_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign count     = srst ? '0 : cnt_q;
    assign afull     = !srst && (cnt_q >= CW'(AFULL_THRESH));

    assign push = in_valid && in_ack;
    assign pop  = out_valid && out_ack && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/user_adpt_stream_bridge.sv
// Per-channel PCIe <-> user stream bridge: a write FIFO and a read FIFO per
// channel, with loopback steering the write FIFO straight into the read FIFO.
module user_adpt_stream_bridge
    import user_adpt_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14
) (
    input  logic                             i_user_clk,
    input  logic                             i_rst,
    input  logic [NUM_CH-1:0]                i_loopback,
    input  logic [NUM_CH-1:0]                i_flush,
    input  logic [NUM_CH-1:0]                i_pcie_str_data_valid,
    output logic [NUM_CH-1:0]                o_pcie_str_ack,
    input  logic [NUM_CH*DATA_W-1:0]         i_pcie_str_data,
    output logic [NUM_CH-1:0]                o_pcie_str_data_valid,
    input  logic [NUM_CH-1:0]                i_pcie_str_ack,
    output logic [NUM_CH*DATA_W-1:0]         o_pcie_str_data,
    output logic [NUM_CH-1:0]                o_pcie_adpt_str_data_valid,
    input  logic [NUM_CH-1:0]                i_pcie_adpt_str_ack,
    output logic [NUM_CH*DATA_W-1:0]         o_pcie_adpt_str_data,
    input  logic [NUM_CH-1:0]                i_pcie_adpt_str_data_valid,
    output logic [NUM_CH-1:0]                o_pcie_adpt_str_ack,
    input  logic [NUM_CH*DATA_W-1:0]         i_pcie_adpt_str_data,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0]   o_wr_cnt,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0]   o_rd_cnt,
    output logic [NUM_CH-1:0]                o_wr_afull,
    output logic [NUM_CH-1:0]                o_rd_afull
);

    localparam int CW = cnt_w(DEPTH);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int LO = ch_lsb(gi, DATA_W);

        logic              wr_out_valid;
        logic [DATA_W-1:0] wr_out_data;
        logic              wr_out_ack;
        logic              rd_in_valid;
        logic [DATA_W-1:0] rd_in_data;
        logic              rd_in_ack;

        // In loopback the read FIFO's ack becomes the write FIFO's pop, so a
        // word only leaves one FIFO on the edge it enters the other.
        assign wr_out_ack  = i_loopback[gi] ? rd_in_ack    : i_pcie_adpt_str_ack[gi];
        assign rd_in_valid = i_loopback[gi] ? wr_out_valid : i_pcie_adpt_str_data_valid[gi];
        assign rd_in_data  = i_loopback[gi] ? wr_out_data  : i_pcie_adpt_str_data[LO +: DATA_W];

        assign o_pcie_adpt_str_data_valid[gi]   = !i_loopback[gi] && wr_out_valid;
        assign o_pcie_adpt_str_data[LO +: DATA_W] = i_loopback[gi] ? '0 : wr_out_data;
        assign o_pcie_adpt_str_ack[gi]          = !i_loopback[gi] && rd_in_ack;

        user_adpt_sync_fifo #(
            .DATA_W       (DATA_W),
            .DEPTH        (DEPTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_wr_fifo (
            .clk       (i_user_clk),
            .srst      (i_rst),
            .flush     (i_flush[gi]),
            .in_valid  (i_pcie_str_data_valid[gi]),
            .in_data   (i_pcie_str_data[LO +: DATA_W]),
            .in_ack    (o_pcie_str_ack[gi]),
            .out_valid (wr_out_valid),
            .out_data  (wr_out_data),
            .out_ack   (wr_out_ack),
            .count     (o_wr_cnt[gi*CW +: CW]),
            .afull     (o_wr_afull[gi])
        );

        user_adpt_sync_fifo #(
            .DATA_W       (DATA_W),
            .DEPTH        (DEPTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_rd_fifo (
            .clk       (i_user_clk),
            .srst      (i_rst),
            .flush     (i_flush[gi]),
            .in_valid  (rd_in_valid),
            .in_data   (rd_in_data),
            .in_ack    (rd_in_ack),
            .out_valid (o_pcie_str_data_valid[gi]),
            .out_data  (o_pcie_str_data[LO +: DATA_W]),
            .out_ack   (i_pcie_str_ack[gi]),
            .count     (o_rd_cnt[gi*CW +: CW]),
            .afull     (o_rd_afull[gi])
        );
    end

endmodule

// File: tb/tb_user_adpt_stream_bridge.sv
// Bench for user_adpt_stream_bridge: directed scenarios plus randomized traffic
// compared against a queue-based per-channel model.
module tb_user_adpt_stream_bridge;

    localparam int NCH   = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int THR   = 14;
    localparam int CW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCH-1:0]      lb, fl;
    logic [NCH-1:0]      pin_valid, pin_ack, pout_valid, pout_ack;
    logic [NCH-1:0]      uout_valid, uout_ack, uin_valid, uin_ack;
    logic [NCH*DW-1:0]   pin_data, pout_data, uout_data, uin_data;
    logic [NCH*CW-1:0]   wr_cnt, rd_cnt;
    logic [NCH-1:0]      wr_af, rd_af;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per FIFO.
    logic [DW-1:0] wq [NCH][$];
    logic [DW-1:0] rq [NCH][$];

    user_adpt_stream_bridge #(
        .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(THR)
    ) dut (
        .i_user_clk                 (clk),
        .i_rst                      (rst),
        .i_loopback                 (lb),
        .i_flush                    (fl),
        .i_pcie_str_data_valid      (pin_valid),
        .o_pcie_str_ack             (pin_ack),
        .i_pcie_str_data            (pin_data),
        .o_pcie_str_data_valid      (pout_valid),
        .i_pcie_str_ack             (pout_ack),
        .o_pcie_str_data            (pout_data),
        .o_pcie_adpt_str_data_valid (uout_valid),
        .i_pcie_adpt_str_ack        (uout_ack),
        .o_pcie_adpt_str_data       (uout_data),
        .i_pcie_adpt_str_data_valid (uin_valid),
        .o_pcie_adpt_str_ack        (uin_ack),
        .i_pcie_adpt_str_data       (uin_data),
        .o_wr_cnt                   (wr_cnt),
        .o_rd_cnt                   (rd_cnt),
        .o_wr_afull                 (wr_af),
        .o_rd_afull                 (rd_af)
    );

    // Apply one clock edge of the specified transfer rules to the queues.
    task automatic model_edge();
        int wsz, rsz;
        bit wpush, wpop, rpush, rpop;
        logic [DW-1:0] rword;
        for (int k = 0; k < NCH; k++) begin
            if (rst || fl[k]) begin
                wq[k].delete();
                rq[k].delete();
            end else begin
                wsz   = wq[k].size();
                rsz   = rq[k].size();
                wpush = pin_valid[k] && (wsz < DEPTH);
                rpop  = (rsz > 0) && pout_ack[k];
                rword = '0;
                if (lb[k]) begin
                    wpop  = (wsz > 0) && (rsz < DEPTH);
                    rpush = wpop;
                    if (wpop) rword = wq[k][0];
                end else begin
                    wpop  = (wsz > 0) && uout_ack[k];
                    rpush = uin_valid[k] && (rsz < DEPTH);
                    rword = uin_data[k*DW +: DW];
                end
                if (wpop)  void'(wq[k].pop_front());
                if (wpush) wq[k].push_back(pin_data[k*DW +: DW]);
                if (rpop)  void'(rq[k].pop_front());
                if (rpush) rq[k].push_back(rword);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lb = '0; fl = '0;
        pin_valid = '0; pout_ack = '0; uout_ack = '0; uin_valid = '0;
        pin_data = '0; uin_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        pin_valid = '1; uin_valid = '1; uout_ack = '1; pout_ack = '1;
        pin_data = {NCH{64'h1234_5678_9abc_def0}};
        repeat (2) tick();
        n_checks++; if (pin_ack !== '0) $display("FAIL reset_pin_ack got=%h exp=0", pin_ack); else n_pass++;
        n_checks++; if (uin_ack !== '0) $display("FAIL reset_uin_ack got=%h exp=0", uin_ack); else n_pass++;
        n_checks++; if ({pout_valid, uout_valid} !== '0) $display("FAIL reset_valids got=%h exp=0", {pout_valid, uout_valid}); else n_pass++;
        n_checks++; if ({pout_data, uout_data} !== '0) $display("FAIL reset_data got=%h exp=0", {pout_data, uout_data}); else n_pass++;
        n_checks++; if ({wr_cnt, rd_cnt} !== '0) $display("FAIL reset_cnt got=%h exp=0", {wr_cnt, rd_cnt}); else n_pass++;
        n_checks++; if ({wr_af, rd_af} !== '0) $display("FAIL reset_afull got=%h exp=0", {wr_af, rd_af}); else n_pass++;
        idle_inputs();
        rst = 1'b0;
        #1;
        n_checks++; if (pin_ack !== 4'hF) $display("FAIL release_pin_ack got=%h exp=f", pin_ack); else n_pass++;
        n_checks++; if (uin_ack !== 4'hF) $display("FAIL release_uin_ack got=%h exp=f", uin_ack); else n_pass++;
        tick();
    endtask

    task automatic test_single_word();
        pin_valid[0] = 1'b1;
        pin_data[0 +: DW] = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_checks++; if (pin_ack[0] !== 1'b1) $display("FAIL single_ack got=%b exp=1", pin_ack[0]); else n_pass++;
        tick();
        pin_valid = '0;
        #1;
        n_checks++; if (uout_valid[0] !== 1'b1) $display("FAIL single_valid got=%b exp=1", uout_valid[0]); else n_pass++;
        n_checks++; if (uout_data[0 +: DW] !== 64'hDEAD_BEEF_0000_0001) $display("FAIL single_data got=%h exp=deadbeef00000001", uout_data[0 +: DW]); else n_pass++;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd1) $display("FAIL single_cnt got=%0d exp=1", wr_cnt[0 +: CW]); else n_pass++;
        uout_ack[0] = 1'b1;
        tick();
        uout_ack[0] = 1'b0;
        #1;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd0) $display("FAIL single_drain_cnt got=%0d exp=0", wr_cnt[0 +: CW]); else n_pass++;
        n_checks++; if ({uout_valid[0], uout_data[0 +: DW]} !== '0) $display("FAIL single_idle_out got=%h exp=0", {uout_valid[0], uout_data[0 +: DW]}); else n_pass++;
    endtask

    task automatic test_fill_backpressure();
        logic [DW-1:0] exp_q [$];
        for (int i = 1; i <= DEPTH; i++) begin
            pin_valid[0] = 1'b1;
            pin_data[0 +: DW] = 64'(i);
            #1;
            n_checks++; if (pin_ack[0] !== 1'b1) $display("FAIL fill_ack word=%0d got=%b exp=1", i, pin_ack[0]); else n_pass++;
            n_checks++; if (wr_cnt[0 +: CW] !== 5'(i - 1)) $display("FAIL fill_cnt word=%0d got=%0d exp=%0d", i, wr_cnt[0 +: CW], i - 1); else n_pass++;
            n_checks++; if (wr_af[0] !== ((i - 1) >= THR)) $display("FAIL fill_afull word=%0d got=%b exp=%b", i, wr_af[0], (i - 1) >= THR); else n_pass++;
            tick();
        end
        pin_data[0 +: DW] = 64'd17;
        #1;
        n_checks++; if (pin_ack[0] !== 1'b0) $display("FAIL full_ack got=%b exp=0", pin_ack[0]); else n_pass++;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd16) $display("FAIL full_cnt got=%0d exp=16", wr_cnt[0 +: CW]); else n_pass++;
        n_checks++; if (wr_af[0] !== 1'b1) $display("FAIL full_afull got=%b exp=1", wr_af[0]); else n_pass++;
        tick();
        // Pop while full with a push offered: push must still be refused.
        uout_ack[0] = 1'b1;
        pin_data[0 +: DW] = 64'd100;
        #1;
        n_checks++; if (pin_ack[0] !== 1'b0) $display("FAIL pushpop_full_ack got=%b exp=0", pin_ack[0]); else n_pass++;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd16) $display("FAIL word17_dropped_cnt got=%0d exp=16", wr_cnt[0 +: CW]); else n_pass++;
        n_checks++; if (uout_data[0 +: DW] !== 64'd1) $display("FAIL pushpop_full_head got=%h exp=1", uout_data[0 +: DW]); else n_pass++;
        tick();
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd15) $display("FAIL after_full_pop_cnt got=%0d exp=15", wr_cnt[0 +: CW]); else n_pass++;
        n_checks++; if (pin_ack[0] !== 1'b1) $display("FAIL pushpop_ack got=%b exp=1", pin_ack[0]); else n_pass++;
        tick();
        pin_valid[0] = 1'b0;
        #1;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd15) $display("FAIL pushpop_cnt got=%0d exp=15", wr_cnt[0 +: CW]); else n_pass++;
        for (int i = 3; i <= DEPTH; i++) exp_q.push_back(64'(i));
        exp_q.push_back(64'd100);
        foreach (exp_q[j]) begin
            n_checks++; if ({uout_valid[0], uout_data[0 +: DW]} !== {1'b1, exp_q[j]}) $display("FAIL drain_order idx=%0d got=%b/%h exp=1/%h", j, uout_valid[0], uout_data[0 +: DW], exp_q[j]); else n_pass++;
            tick();
        end
        uout_ack[0] = 1'b0;
        n_checks++; if ({uout_valid[0], wr_cnt[0 +: CW]} !== '0) $display("FAIL drain_empty got=%b/%0d exp=0/0", uout_valid[0], wr_cnt[0 +: CW]); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [DW-1:0] got [$];
        int sent = 0;
        int cyc = 0;
        int first = -1;
        pout_ack[2] = 1'b1;
        while (got.size() < 32 && cyc < 200) begin
            lb[2] = !(cyc >= 10 && cyc < 14);
            pin_valid[2] = (sent < 32);
            pin_data[2*DW +: DW] = 64'(sent);
            #1;
            if (lb[2]) begin
                n_checks++; if ({uout_valid[2], uin_ack[2]} !== 2'b00) $display("FAIL lb_user_side cyc=%0d got=%b exp=00", cyc, {uout_valid[2], uin_ack[2]}); else n_pass++;
            end
            if (pout_valid[2]) begin
                if (first < 0) first = cyc;
                got.push_back(pout_data[2*DW +: DW]);
            end
            if (pin_valid[2] && pin_ack[2]) sent++;
            tick();
            cyc++;
        end
        idle_inputs();
        n_checks++; if (got.size() !== 32) $display("FAIL lb_word_count got=%0d exp=32", got.size()); else n_pass++;
        n_checks++; if (first !== 2) $display("FAIL lb_latency got=%0d exp=2", first); else n_pass++;
        foreach (got[i]) begin
            n_checks++; if (got[i] !== 64'(i)) $display("FAIL lb_order idx=%0d got=%h exp=%h", i, got[i], 64'(i)); else n_pass++;
        end
    endtask

    task automatic test_flush();
        fl = '1;
        tick();
        fl = '0;
        for (int i = 0; i < 5; i++) begin
            pin_valid = {(i < 3), 1'b0, 1'b1, (i < 2)};
            for (int k = 0; k < NCH; k++) pin_data[k*DW +: DW] = 64'((k << 8) | i);
            tick();
        end
        pin_valid = '0;
        fl[1] = 1'b1;
        pin_valid[1] = 1'b1;
        pin_data[DW +: DW] = 64'hF1;
        uin_valid[1] = 1'b1;
        pin_valid[0] = 1'b1;
        pin_data[0 +: DW] = 64'hE0;
        #1;
        n_checks++; if (wr_cnt[CW +: CW] !== 5'd5) $display("FAIL flush_pre_cnt got=%0d exp=5", wr_cnt[CW +: CW]); else n_pass++;
        n_checks++; if ({pin_ack[1], uin_ack[1]} !== 2'b00) $display("FAIL flush_acks got=%b exp=00", {pin_ack[1], uin_ack[1]}); else n_pass++;
        n_checks++; if (pin_ack[0] !== 1'b1) $display("FAIL flush_other_ack got=%b exp=1", pin_ack[0]); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if ({wr_cnt[CW +: CW], rd_cnt[CW +: CW]} !== '0) $display("FAIL flush_cnt got=%0d/%0d exp=0/0", wr_cnt[CW +: CW], rd_cnt[CW +: CW]); else n_pass++;
        n_checks++; if ({uout_valid[1], uout_data[DW +: DW]} !== '0) $display("FAIL flush_out got=%b/%h exp=0/0", uout_valid[1], uout_data[DW +: DW]); else n_pass++;
        n_checks++; if (wr_cnt[0 +: CW] !== 5'd3) $display("FAIL flush_ch0_cnt got=%0d exp=3", wr_cnt[0 +: CW]); else n_pass++;
        n_checks++; if (wr_cnt[3*CW +: CW] !== 5'd3) $display("FAIL flush_ch3_cnt got=%0d exp=3", wr_cnt[3*CW +: CW]); else n_pass++;
        pin_valid[1] = 1'b1;
        pin_data[DW +: DW] = 64'hA5;
        tick();
        pin_valid = '0;
        #1;
        n_checks++; if ({uout_valid[1], uout_data[DW +: DW]} !== {1'b1, 64'hA5}) $display("FAIL post_flush_head got=%b/%h exp=1/a5", uout_valid[1], uout_data[DW +: DW]); else n_pass++;
        fl = '1;
        tick();
        fl = '0;
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 8; i++) begin
            pin_valid[0] = 1'b1;
            pin_data[0 +: DW] = 64'(200 + i);
            uin_valid[3] = 1'b1;
            uin_data[3*DW +: DW] = 64'(300 + i);
            tick();
        end
        idle_inputs();
        #1;
        n_checks++; if ({wr_cnt[0 +: CW], rd_cnt[3*CW +: CW]} !== {5'd8, 5'd8}) $display("FAIL midrst_pre_cnt got=%0d/%0d exp=8/8", wr_cnt[0 +: CW], rd_cnt[3*CW +: CW]); else n_pass++;
        rst = 1'b1;
        uout_ack = '1; pout_ack = '1; pin_valid = '1;
        #1;
        n_checks++; if ({pout_valid, uout_valid, pin_ack, uin_ack} !== '0) $display("FAIL midrst_flags got=%h exp=0", {pout_valid, uout_valid, pin_ack, uin_ack}); else n_pass++;
        n_checks++; if ({pout_data, uout_data} !== '0) $display("FAIL midrst_data got=%h exp=0", {pout_data, uout_data}); else n_pass++;
        n_checks++; if ({wr_cnt, rd_cnt, wr_af, rd_af} !== '0) $display("FAIL midrst_status got=%h exp=0", {wr_cnt, rd_cnt, wr_af, rd_af}); else n_pass++;
        repeat (2) tick();
        rst = 1'b0;
        pin_valid = '0;
        #1;
        n_checks++; if ({wr_cnt, rd_cnt} !== '0) $display("FAIL postrst_cnt got=%h exp=0", {wr_cnt, rd_cnt}); else n_pass++;
        n_checks++; if (pin_ack !== 4'hF) $display("FAIL postrst_ack got=%h exp=f", pin_ack); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if ({pout_valid, uout_valid} !== '0) $display("FAIL postrst_stale cyc=%0d got=%h exp=0", c, {pout_valid, uout_valid}); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NCH-1:0]    e_pin_ack, e_uin_ack, e_uout_valid, e_pout_valid, e_wr_af, e_rd_af;
        logic [NCH*DW-1:0] e_uout_data, e_pout_data;
        logic [NCH*CW-1:0] e_wr_cnt, e_rd_cnt;
        bit fill;
        for (int cyc = 0; cyc < 600; cyc++) begin
            fill = ((cyc / 100) % 2) == 0;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 19) == 0) lb[k] = ~lb[k];
                fl[k]        = ($urandom_range(0, 79) == 0);
                pin_valid[k] = ($urandom_range(0, 3) != 0);
                uin_valid[k] = ($urandom_range(0, 3) != 0);
                uout_ack[k]  = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                pout_ack[k]  = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                pin_data[k*DW +: DW] = {$urandom, $urandom};
                uin_data[k*DW +: DW] = {$urandom, $urandom};
            end
            #1;
            for (int k = 0; k < NCH; k++) begin
                e_pin_ack[k]    = (wq[k].size() < DEPTH) && !fl[k];
                e_uin_ack[k]    = !lb[k] && (rq[k].size() < DEPTH) && !fl[k];
                e_uout_valid[k] = !lb[k] && (wq[k].size() > 0);
                e_pout_valid[k] = (rq[k].size() > 0);
                e_uout_data[k*DW +: DW] = e_uout_valid[k] ? wq[k][0] : '0;
                e_pout_data[k*DW +: DW] = e_pout_valid[k] ? rq[k][0] : '0;
                e_wr_cnt[k*CW +: CW] = CW'(wq[k].size());
                e_rd_cnt[k*CW +: CW] = CW'(rq[k].size());
                e_wr_af[k] = (wq[k].size() >= THR);
                e_rd_af[k] = (rq[k].size() >= THR);
            end
            n_checks++; if (pin_ack !== e_pin_ack) $display("FAIL rnd_pin_ack cyc=%0d got=%h exp=%h", cyc, pin_ack, e_pin_ack); else n_pass++;
            n_checks++; if (uin_ack !== e_uin_ack) $display("FAIL rnd_uin_ack cyc=%0d got=%h exp=%h", cyc, uin_ack, e_uin_ack); else n_pass++;
            n_checks++; if (uout_valid !== e_uout_valid) $display("FAIL rnd_uout_valid cyc=%0d got=%h exp=%h", cyc, uout_valid, e_uout_valid); else n_pass++;
            n_checks++; if (pout_valid !== e_pout_valid) $display("FAIL rnd_pout_valid cyc=%0d got=%h exp=%h", cyc, pout_valid, e_pout_valid); else n_pass++;
            n_checks++; if (uout_data !== e_uout_data) $display("FAIL rnd_uout_data cyc=%0d got=%h exp=%h", cyc, uout_data, e_uout_data); else n_pass++;
            n_checks++; if (pout_data !== e_pout_data) $display("FAIL rnd_pout_data cyc=%0d got=%h exp=%h", cyc, pout_data, e_pout_data); else n_pass++;
            n_checks++; if (wr_cnt !== e_wr_cnt) $display("FAIL rnd_wr_cnt cyc=%0d got=%h exp=%h", cyc, wr_cnt, e_wr_cnt); else n_pass++;
            n_checks++; if (rd_cnt !== e_rd_cnt) $display("FAIL rnd_rd_cnt cyc=%0d got=%h exp=%h", cyc, rd_cnt, e_rd_cnt); else n_pass++;
            n_checks++; if (wr_af !== e_wr_af) $display("FAIL rnd_wr_afull cyc=%0d got=%h exp=%h", cyc, wr_af, e_wr_af); else n_pass++;
            n_checks++; if (rd_af !== e_rd_af) $display("FAIL rnd_rd_afull cyc=%0d got=%h exp=%h", cyc, rd_af, e_rd_af); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_word();
        test_fill_backpressure();
        test_loopback();
        test_flush();
        test_reset_mid_stream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
